rf_writeback_arbiter: RTL and testbench
=======================================

# rf_writeback_arbiter

Shares the register file's single write port among multiple writeback requesters (e.g. ALU, load unit, multicycle mul/div) using round-robin arbitration with a valid/ready handshake. It registers the winning write one cycle before presenting it to the register file write port. It also keeps a per-register pending-write scoreboard so issue logic can detect RAW/WAW hazards. It sits between the execute/memory stages and the register file, which writes on posedge.

## Interface
Parameters:
- NUM_REQ, 2: number of writeback requesters (2..4).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_rd  in  NUM_REQ*5  destination register, slice i = [5i+4:5i].
- req_data  in  NUM_REQ*32  write data, slice i = [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- rf_rd  out  5  register file write address (registered).
- rf_write_data  out  32  register file write data (registered).
- rf_write_en  out  1  register file write enable (registered).
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  5  destination of the issued instruction.
- chk_rs1, chk_rs2, chk_rd  in  5 each  operands/destination of the instruction being considered for issue.
- hazard  out  1  combinational: any nonzero chk_* register is pending.
- pending  out  32  scoreboard bitmask, bit 0 always 0.
- sb_err  out  1  sticky: issue to an already-pending register.

## Operation
- Arbitration: each cycle the first valid requester at or after rr_ptr (wrapping modulo NUM_REQ) is granted. req_ready is combinational and 0 while rst is high. At most one bit is set. The write stage always accepts, so a valid requester is never refused more than NUM_REQ-1 cycles.
- rr_ptr update: on a transfer from i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Write stage: a transfer loads rf_rd/rf_write_data and sets rf_write_en=1 for exactly the next cycle. rf_write_en=0 if the transferred rd is 0; that request is still consumed. With no transfer, rf_write_en=0 and rf_rd/rf_write_data hold their previous values.
- Scoreboard, at each posedge:
  - A set is issue_valid & issue_rd≠0.
  - A clear is rf_write_en & rf_rd≠0.
  - Clear and set on the same register in the same cycle: set wins.
  - A set on a register whose bit is already 1 and is not being cleared that cycle sets sb_err.
- hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd], with index 0 treated as 0. It uses registered pending only, with no bypass.
- Requesters must hold req_rd/req_data stable while valid and not ready.

## Timing
- Reset values: rf_write_en=0, rf_rd=0, rf_write_data=0, pending=0, sb_err=0, rr_ptr=0.
- Reset mid-operation: any write registered in the stage is dropped (rf_write_en=0 the cycle after rst). The scoreboard is cleared.
- Latency: transfer at cycle N gives rf_write_en=1 in cycle N+1. The register file commits at the end of N+1, and the pending bit clears at the same edge. The value is readable and hazard drops in cycle N+2.
- Throughput: one write per cycle. Back-to-back grants are allowed.
- Issue at cycle N makes pending visible, and hazard able to assert, from cycle N+1.

## Structure
- Shared package regfile_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, and typedef wb_req_t {rd, data}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- The top level holds the write stage register, rr_ptr, scoreboard and hazard logic.

## Test plan
- Reset then idle: after rst, all outputs 0 and req_ready=0 during rst. hazard=0 for chk_rs1=5.
- Single write: req0 valid rd=7 data=0xDEADBEEF at cycle N. Requires req_ready[0]=1 at N, then rf_write_en=1, rf_rd=7, rf_write_data=0xDEADBEEF at N+1, then rf_write_en=0 at N+2.
- Round-robin fairness: req0 and req1 both held valid for 4 cycles (rd=1/2). Grants must be 0,1,0,1, with rf_rd sequence 1,2,1,2.
- Scoreboard:
  - issue rd=9 at N gives pending[9]=1 and hazard=1 for chk_rs2=9 at N+1.
  - A writeback of rd=9 committed at M gives hazard=0 at M+1.
- Edge cases:
  - Issue rd=9 in the same cycle rf_write_en clears rd=9: pending[9] stays 1 and sb_err=0.
  - A second issue rd=9 while pending sets sb_err=1, which stays set until rst.
  - Writeback rd=0 is consumed with rf_write_en=0.
- Mid-operation reset: rst asserted in the cycle after a transfer. Requires rf_write_en=0, pending=0, rr_ptr=0, so req0 wins the first post-reset contention.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any_grant
);

    // Search offsets from farthest to nearest so the requester closest to rr_ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            for (int p = 0; p < N; p++) begin
                if (rr_ptr == PTR_W'(p) && req[(p + k) % N]) begin
                    grant               = '0;
                    grant[(p + k) % N]  = 1'b1;
                    grant_idx           = PTR_W'((p + k) % N);
                    any_grant           = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: round-robin grant onto one registered write port,
// plus a pending-write scoreboard for issue hazard detection.
module rf_writeback_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [4:0]              rf_rd,
    output logic [31:0]             rf_write_data,
    output logic                    rf_write_en,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [4:0]              chk_rs1,
    input  logic [4:0]              chk_rs2,
    input  logic [4:0]              chk_rd,
    output logic                    hazard,
    output logic [31:0]             pending,
    output logic                    sb_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    wb_req_t              req_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 any_grant;
    logic                 transfer;
    wb_req_t              sel_req;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [4:0]           rf_rd_q, rf_rd_d;
    logic [31:0]          rf_data_q, rf_data_d;
    logic                 rf_we_q, rf_we_d;
    logic [31:0]          pending_q, pending_d;
    logic                 sb_err_q, sb_err_d;
    logic [31:0]          set_vec, clr_vec;

    // Unpack the flat requester buses into records.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_arr[gi].rd   = req_rd[5*gi +: 5];
            assign req_arr[gi].data = req_data[32*gi +: 32];
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // The write stage always accepts, so the grant is the ready; suppressed during reset.
    assign req_ready = rst ? '0 : grant;
    assign transfer  = any_grant & ~rst;
    assign sel_req   = req_arr[grant_idx];

    // Next-state for the pointer and the write stage; rd=0 is consumed but never written.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        rf_we_d   = 1'b0;
        if (transfer) begin
            rr_ptr_d  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            rf_rd_d   = sel_req.rd;
            rf_data_d = sel_req.data;
            rf_we_d   = (sel_req.rd != 5'd0);
        end
    end

    // Per-register set (issue) and clear (committed writeback) strobes; register 0 never tracked.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign set_vec[gi] = 1'b0;
                assign clr_vec[gi] = 1'b0;
            end else begin : g_reg
                assign set_vec[gi] = issue_valid & (issue_rd == 5'(gi));
                assign clr_vec[gi] = rf_we_q & (rf_rd_q == 5'(gi));
            end
        end
    endgenerate

    // Set wins over clear; re-issuing to a still-pending register latches the error.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        sb_err_d  = sb_err_q | (|(set_vec & pending_q & ~clr_vec));
    end

    // All state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            rf_we_q   <= 1'b0;
            pending_q <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            rf_we_q   <= rf_we_d;
            pending_q <= pending_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_data_q;
    assign rf_write_en   = rf_we_q;
    assign pending       = pending_q;
    assign sb_err        = sb_err_q;

    // Registered pending only; bit 0 is never set so x0 operands never hazard.
    assign hazard = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[chk_rd];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with hand-computed expectations.
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [9:0]  req_rd;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic [4:0]  rf_rd;
    logic [31:0] rf_write_data;
    logic        rf_write_en;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic [31:0] pending;
    logic        sb_err;

    int n_checks = 0;
    int n_pass   = 0;

    rf_writeback_arbiter #(.NUM_REQ(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .rf_write_en   (rf_write_en),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .chk_rs1       (chk_rs1),
        .chk_rs2       (chk_rs2),
        .chk_rd        (chk_rd),
        .hazard        (hazard),
        .pending       (pending),
        .sb_err        (sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=0x%08h", tag, got);
        end else begin
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; req_rd = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;

        // Reset then idle
        settle();
        check("ready_in_reset", 32'(req_ready), 32'h0);
        step(); step();
        rst = 1'b0; req_valid = 2'b00; chk_rs1 = 5'd5;
        settle();
        check("rst_we",     32'(rf_write_en),   32'h0);
        check("rst_rd",     32'(rf_rd),         32'h0);
        check("rst_data",   rf_write_data,      32'h0);
        check("rst_pend",   pending,            32'h0);
        check("rst_sberr",  32'(sb_err),        32'h0);
        check("rst_hazard", 32'(hazard),        32'h0);
        chk_rs1 = 5'd0;

        // Round-robin fairness: both valid for four cycles
        req_valid = 2'b11; req_rd = {5'd2, 5'd1}; req_data = {32'hA2A2A2A2, 32'hA1A1A1A1};
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("rr_grant%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check($sformatf("rr_rd%0d", k),   32'(rf_rd), (k % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("rr_we%0d", k),   32'(rf_write_en), 32'h1);
        end
        req_valid = 2'b00;

        // Single write from requester 0
        req_valid = 2'b01; req_rd = {5'd0, 5'd7}; req_data = {32'h0, 32'hDEADBEEF};
        settle();
        check("sw_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check("sw_we",   32'(rf_write_en), 32'h1);
        check("sw_rd",   32'(rf_rd),       32'd7);
        check("sw_data", rf_write_data,    32'hDEADBEEF);
        step();
        check("sw_we_off",  32'(rf_write_en), 32'h0);
        check("sw_rd_hold", 32'(rf_rd),       32'd7);

        // Scoreboard: issue rd=9, then its writeback clears it
        issue_valid = 1'b1; issue_rd = 5'd9; chk_rs2 = 5'd9;
        step();
        issue_valid = 1'b0;
        check("sb_pend9",  pending,       32'h0000_0200);
        check("sb_hazard", 32'(hazard),   32'h1);
        req_valid = 2'b01; req_rd = {5'd0, 5'd9}; req_data = {32'h0, 32'h00000099};
        step();
        req_valid = 2'b00;
        check("sb_wb_we",    32'(rf_write_en), 32'h1);
        check("sb_haz_M",    32'(hazard),      32'h1);
        step();
        check("sb_haz_M1",   32'(hazard),      32'h0);
        check("sb_pend_clr", pending,          32'h0);

        // Issue rd=9 in the same cycle its writeback clears it: set wins, no error
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        req_valid = 2'b01; req_rd = {5'd0, 5'd9};
        step();
        req_valid = 2'b00;
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        check("same_pend", pending,        32'h0000_0200);
        check("same_err",  32'(sb_err),    32'h0);

        // Second issue to a pending register with no clear: sticky error
        issue_valid = 1'b1; issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        check("err_set", 32'(sb_err), 32'h1);
        step(); step();
        check("err_sticky", 32'(sb_err), 32'h1);

        // Writeback to rd=0 is consumed without a write
        req_valid = 2'b10; req_rd = {5'd0, 5'd0}; req_data = {32'h00000055, 32'h0};
        settle();
        check("x0_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        check("x0_we",   32'(rf_write_en), 32'h0);
        check("x0_rd",   32'(rf_rd),       32'h0);
        check("x0_data", rf_write_data,    32'h00000055);
        check("x0_pend", pending,          32'h0000_0200);

        // Mid-operation reset: transfer from req0 leaves rr_ptr at 1, then reset
        req_valid = 2'b01; req_rd = {5'd4, 5'd3}; req_data = {32'h44, 32'h33};
        step();
        check("mr_we_pre", 32'(rf_write_en), 32'h1);
        rst = 1'b1; req_valid = 2'b11;
        settle();
        check("mr_ready_rst", 32'(req_ready), 32'h0);
        step();
        rst = 1'b0;
        settle();
        check("mr_we",    32'(rf_write_en), 32'h0);
        check("mr_pend",  pending,          32'h0);
        check("mr_err",   32'(sb_err),      32'h0);
        check("mr_grant", 32'(req_ready),   32'h1);
        step();
        req_valid = 2'b00;
        check("mr_rd", 32'(rf_rd), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
